light_decryptor_arbiter: RTL and testbench
==========================================

Name: light_decryptor_arbiter

Overview:
- Shares one light_decryptor instance between NUM_REQ independent requesters.
- Uses round-robin arbitration with exactly one transaction outstanding in the decryptor at a time.
- Latches the winning ciphertext, sequences the decryptor val/rdy handshakes, captures plaintext+HMAC, and returns the result to the granted requester only.
- Sits between the host-side requester ports and the decryptor core.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- CT_WIDTH, 640, ciphertext/plaintext width in bits.
- HMAC_WIDTH, 128, HMAC width in bits.
- ID_WIDTH, $clog2(NUM_REQ), grant index width.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_ciphertext  input  NUM_REQ*CT_WIDTH  packed ciphertexts; requester i occupies bits [i*CT_WIDTH +: CT_WIDTH].
- req_val  input  NUM_REQ  per-requester request valid.
- req_rdy  output  NUM_REQ  per-requester accept, one-hot or zero.
- resp_plaintext  output  CT_WIDTH  latched plaintext, shared by all requesters.
- resp_hmac  output  HMAC_WIDTH  latched HMAC, shared by all requesters.
- resp_val  output  NUM_REQ  per-requester response valid, one-hot or zero.
- resp_rdy  input  NUM_REQ  per-requester response ready.
- dec_req_ciphertext  output  CT_WIDTH  to decryptor req_ciphertext.
- dec_req_val  output  1  to decryptor req_val.
- dec_req_rdy  input  1  from decryptor req_rdy.
- dec_resp_plaintext  input  CT_WIDTH  from decryptor.
- dec_resp_hmac  input  HMAC_WIDTH  from decryptor.
- dec_resp_val  input  1  from decryptor.
- dec_resp_rdy  output  1  to decryptor resp_rdy.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  ID_WIDTH  index of the current or most recent grantee.

Behaviour:
- Reset (async assert, sync deassert of effect): state=IDLE; all outputs 0; ct/pt/hmac registers cleared; last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, ISSUE, WAIT_RESP, DELIVER.
- IDLE:
  - Winner = first i with req_val[i]=1, searching from last_grant+1 upward with wrap modulo NUM_REQ.
  - req_rdy is combinational: only bit[winner] is set, and only in IDLE.
  - On req_val[w]&req_rdy[w]: latch ciphertext slice w, set grant_id=w, go to ISSUE.
  - No request pending: stay in IDLE with req_rdy=0.
- ISSUE:
  - dec_req_val=1 and dec_req_ciphertext=latched ct, both driven from registers.
  - On dec_req_rdy=1 at posedge: go to WAIT_RESP.
  - dec_req_val stays high until accepted; ciphertext stays stable throughout.
- WAIT_RESP:
  - dec_resp_rdy=1.
  - On dec_resp_val=1: latch plaintext and HMAC, go to DELIVER.
  - dec_resp_val observed in any other state is ignored, because dec_resp_rdy=0.
- DELIVER:
  - resp_val[grant_id]=1; resp_plaintext/resp_hmac hold the latched values.
  - On resp_rdy[grant_id]=1: last_grant=grant_id, go to IDLE.
  - resp_rdy from non-granted requesters is ignored.
- resp_plaintext/resp_hmac hold their last values after DELIVER until the next capture.
- Minimum latency from req accept to resp_val: 2 cycles + decryptor latency (ISSUE 1 cycle with dec_req_rdy high, WAIT_RESP ≥1 cycle).
- Back-to-back: after DELIVER completes, IDLE can accept in the very next cycle. Throughput is one transaction per ≥4 cycles.
- A requester dropping req_val before the grant simply loses eligibility; no state is retained for it.
- Fairness: a requester that holds req_val continuously waits at most NUM_REQ-1 transactions.
- Reset mid-operation: the in-flight transaction is abandoned; the FSM returns to IDLE; no response is issued. The decryptor must be reset on the same rst_n.
- Invariants: at most one bit set in req_rdy; at most one bit set in resp_val; dec_req_val and dec_resp_rdy are never high together.

Test Plan:
- Single request: req_val=4'b0001, ct=640'd5 → req_rdy=4'b0001 for 1 cycle; dec_req_ciphertext=640'd5; resp_val=4'b0001 with pt/hmac equal to the decryptor output; busy falls after resp_rdy[0].
- All four requesting continuously, cts 640'd0/5/10/15 → grants in order 0,1,2,3,0; resp_val one-hot and matching grant_id each time.
- Contention after a grant: last_grant=2, req_val=4'b0101 → requester 0 wins (wrap from 3), then requester 2.
- Decryptor stalls: dec_req_rdy held low for 10 cycles → dec_req_val and ciphertext stable for all 10 cycles; no new req_rdy; busy=1.
- Response backpressure: resp_rdy[1]=0 for 8 cycles in DELIVER → resp_val[1] and data held; resp_rdy[0]=1 during that window has no effect.
- Reset in WAIT_RESP: rst_n low for 2 cycles → all outputs 0 immediately, state IDLE; the next req_val=4'b0001 is granted to requester 0.

Source files
------------

// File: rtl/light_decryptor_arbiter.sv
// Round-robin arbiter that shares a single light_decryptor core between
// NUM_REQ requesters, keeping exactly one transaction in flight at a time.
module light_decryptor_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CT_WIDTH   = 640,
  parameter int unsigned HMAC_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ*CT_WIDTH-1:0] req_ciphertext,
  input  logic [NUM_REQ-1:0]          req_val,
  output logic [NUM_REQ-1:0]          req_rdy,
  output logic [CT_WIDTH-1:0]         resp_plaintext,
  output logic [HMAC_WIDTH-1:0]       resp_hmac,
  output logic [NUM_REQ-1:0]          resp_val,
  input  logic [NUM_REQ-1:0]          resp_rdy,
  output logic [CT_WIDTH-1:0]         dec_req_ciphertext,
  output logic                        dec_req_val,
  input  logic                        dec_req_rdy,
  input  logic [CT_WIDTH-1:0]         dec_resp_plaintext,
  input  logic [HMAC_WIDTH-1:0]       dec_resp_hmac,
  input  logic                        dec_resp_val,
  output logic                        dec_resp_rdy,
  output logic                        busy,
  output logic [ID_WIDTH-1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DELIVER   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CT_WIDTH-1:0]   ct_q;
  logic [CT_WIDTH-1:0]   pt_q;
  logic [HMAC_WIDTH-1:0] hmac_q;
  logic [ID_WIDTH-1:0]   grant_id_q;
  logic [ID_WIDTH-1:0]   last_grant_q;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  deliver_done;

  // Round-robin search: first active requester after last_grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_val[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign deliver_done = resp_rdy[grant_id_q];

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (win_found)    state_d = ISSUE;
      ISSUE:     if (dec_req_rdy)  state_d = WAIT_RESP;
      WAIT_RESP: if (dec_resp_val) state_d = DELIVER;
      DELIVER:   if (deliver_done) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath captures: ciphertext on grant, result on decryptor response,
  // round-robin pointer only once the grantee has taken its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q         <= '0;
      pt_q         <= '0;
      hmac_q       <= '0;
      grant_id_q   <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: if (win_found) begin
          ct_q       <= req_ciphertext[win_idx*CT_WIDTH +: CT_WIDTH];
          grant_id_q <= win_idx;
        end
        WAIT_RESP: if (dec_resp_val) begin
          pt_q   <= dec_resp_plaintext;
          hmac_q <= dec_resp_hmac;
        end
        DELIVER: if (deliver_done) last_grant_q <= grant_id_q;
        default: ;
      endcase
    end
  end

  // Handshake outputs are decoded from the registered state only, except
  // req_rdy which follows the live round-robin winner while idle.
  always_comb begin
    req_rdy      = '0;
    resp_val     = '0;
    dec_req_val  = 1'b0;
    dec_resp_rdy = 1'b0;
    case (state_q)
      IDLE:      if (win_found) req_rdy = NUM_REQ'(1) << win_idx;
      ISSUE:     dec_req_val  = 1'b1;
      WAIT_RESP: dec_resp_rdy = 1'b1;
      DELIVER:   resp_val     = NUM_REQ'(1) << grant_id_q;
      default: ;
    endcase
  end

  assign busy               = (state_q != IDLE);
  assign grant_id           = grant_id_q;
  assign dec_req_ciphertext = ct_q;
  assign resp_plaintext     = pt_q;
  assign resp_hmac          = hmac_q;

endmodule

// File: tb/tb_light_decryptor_arbiter.sv
// Directed bench for light_decryptor_arbiter; the bench plays the decryptor.
module tb_light_decryptor_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned CTW = 640;
  localparam int unsigned HMW = 128;
  localparam int unsigned IDW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*CTW-1:0]   req_ciphertext;
  logic [N-1:0]       req_val;
  logic [N-1:0]       req_rdy;
  logic [CTW-1:0]     resp_plaintext;
  logic [HMW-1:0]     resp_hmac;
  logic [N-1:0]       resp_val;
  logic [N-1:0]       resp_rdy;
  logic [CTW-1:0]     dec_req_ciphertext;
  logic               dec_req_val;
  logic               dec_req_rdy;
  logic [CTW-1:0]     dec_resp_plaintext;
  logic [HMW-1:0]     dec_resp_hmac;
  logic               dec_resp_val;
  logic               dec_resp_rdy;
  logic               busy;
  logic [IDW-1:0]     grant_id;

  int checks = 0;
  int errors = 0;

  light_decryptor_arbiter #(
    .NUM_REQ(N), .CT_WIDTH(CTW), .HMAC_WIDTH(HMW), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ciphertext(req_ciphertext), .req_val(req_val), .req_rdy(req_rdy),
    .resp_plaintext(resp_plaintext), .resp_hmac(resp_hmac),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .dec_req_ciphertext(dec_req_ciphertext), .dec_req_val(dec_req_val),
    .dec_req_rdy(dec_req_rdy), .dec_resp_plaintext(dec_resp_plaintext),
    .dec_resp_hmac(dec_resp_hmac), .dec_resp_val(dec_resp_val),
    .dec_resp_rdy(dec_resp_rdy), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic set_ct(input int i, input logic [CTW-1:0] v);
    req_ciphertext[i*CTW +: CTW] = v;
  endtask

  // Full reset pulse (2 cycles low), checking outputs while reset is held.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_rdy, resp_val, dec_req_val, dec_resp_rdy, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b val=%b dqv=%b drr=%b busy=%b gid=%0d, want all 0",
               req_rdy, resp_val, dec_req_val, dec_resp_rdy, busy, grant_id);
    end
    checks++;
    if ((resp_plaintext !== '0) || (resp_hmac !== '0) || (dec_req_ciphertext !== '0)) begin
      errors++;
      $display("FAIL reset_data: got pt=%h hmac=%h ct=%h, want 0",
               resp_plaintext, resp_hmac, dec_req_ciphertext);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction: caller has set req_val/ciphertexts at a negedge.
  // req_stall cycles of dec_req_rdy low (with a stray dec_resp_val),
  // resp_stall cycles with only non-granted resp_rdy bits high.
  task automatic run_txn(input int id, input logic [CTW-1:0] ct,
                         input logic [CTW-1:0] pt, input logic [HMW-1:0] hm,
                         input int req_stall, input int resp_stall);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    #1;
    checks++;
    if (req_rdy !== oh) begin
      errors++;
      $display("FAIL grant_rdy: got %b want %b", req_rdy, oh);
    end
    @(negedge clk);
    #1;
    checks++;
    if ((dec_req_val !== 1'b1) || (dec_req_ciphertext !== ct) || (grant_id !== IDW'(id)) ||
        (busy !== 1'b1) || (req_rdy !== '0) || (dec_resp_rdy !== 1'b0)) begin
      errors++;
      $display("FAIL issue: got dqv=%b gid=%0d busy=%b rdy=%b drr=%b ct=%h, want 1/%0d/1/0/0 ct=%h",
               dec_req_val, grant_id, busy, req_rdy, dec_resp_rdy, dec_req_ciphertext, id, ct);
    end
    for (int s = 0; s < req_stall; s++) begin
      dec_resp_val       = 1'b1;
      dec_resp_plaintext = '1;
      dec_resp_hmac      = '1;
      @(negedge clk);
      #1;
      checks++;
      if ((dec_req_val !== 1'b1) || (dec_req_ciphertext !== ct) || (req_rdy !== '0) ||
          (busy !== 1'b1) || (resp_val !== '0)) begin
        errors++;
        $display("FAIL req_stall%0d: got dqv=%b rdy=%b busy=%b rv=%b ct=%h, want 1/0/1/0 ct=%h",
                 s, dec_req_val, req_rdy, busy, resp_val, dec_req_ciphertext, ct);
      end
    end
    dec_resp_val = 1'b0;
    dec_req_rdy  = 1'b1;
    @(negedge clk);
    dec_req_rdy = 1'b0;
    #1;
    checks++;
    if ((dec_resp_rdy !== 1'b1) || (dec_req_val !== 1'b0) || (resp_val !== '0)) begin
      errors++;
      $display("FAIL wait_resp: got drr=%b dqv=%b rv=%b, want 1/0/0",
               dec_resp_rdy, dec_req_val, resp_val);
    end
    dec_resp_val       = 1'b1;
    dec_resp_plaintext = pt;
    dec_resp_hmac      = hm;
    @(negedge clk);
    dec_resp_val       = 1'b0;
    dec_resp_plaintext = ~pt;
    dec_resp_hmac      = ~hm;
    #1;
    checks++;
    if ((resp_val !== oh) || (resp_plaintext !== pt) || (resp_hmac !== hm) ||
        (dec_resp_rdy !== 1'b0) || (grant_id !== IDW'(id))) begin
      errors++;
      $display("FAIL deliver: got rv=%b gid=%0d drr=%b pt=%h hmac=%h, want rv=%b gid=%0d pt=%h hmac=%h",
               resp_val, grant_id, dec_resp_rdy, resp_plaintext, resp_hmac, oh, id, pt, hm);
    end
    for (int s = 0; s < resp_stall; s++) begin
      resp_rdy = ~oh;
      @(negedge clk);
      #1;
      checks++;
      if ((resp_val !== oh) || (resp_plaintext !== pt) || (resp_hmac !== hm) ||
          (busy !== 1'b1) || (req_rdy !== '0)) begin
        errors++;
        $display("FAIL resp_stall%0d: got rv=%b busy=%b rdy=%b pt=%h hmac=%h, want rv=%b held",
                 s, resp_val, busy, req_rdy, resp_plaintext, resp_hmac, oh);
      end
    end
    resp_rdy = oh;
    @(negedge clk);
    resp_rdy = '0;
    #1;
    checks++;
    if ((resp_val !== '0) || (busy !== 1'b0) || (resp_plaintext !== pt) || (resp_hmac !== hm)) begin
      errors++;
      $display("FAIL done: got rv=%b busy=%b pt=%h, want rv=0 busy=0 pt=%h held",
               resp_val, busy, resp_plaintext, pt);
    end
  endtask

  task automatic test_single();
    test_reset();
    set_ct(0, CTW'(5));
    req_val = 4'b0001;
    run_txn(0, CTW'(5), CTW'(640'h1234_5678), HMW'(128'hABCD), 0, 0);
    req_val = '0;
    #1;
    checks++;
    if ((req_rdy !== '0) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL idle_no_req: got rdy=%b busy=%b, want 0/0", req_rdy, busy);
    end
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int i = 0; i < 4; i++) set_ct(i, CTW'(5 * i));
    req_val = 4'b1111;
    for (int t = 0; t < 5; t++)
      run_txn(t % 4, CTW'(5 * (t % 4)), CTW'(100 + t), HMW'(200 + t), 0, 0);
    req_val = '0;
  endtask

  task automatic test_contention();
    test_reset();
    set_ct(0, CTW'(640'hA0));
    set_ct(2, CTW'(640'hC2));
    req_val = 4'b0100;
    run_txn(2, CTW'(640'hC2), CTW'(640'h11), HMW'(128'h21), 0, 0);
    req_val = 4'b0101;
    run_txn(0, CTW'(640'hA0), CTW'(640'h12), HMW'(128'h22), 0, 0);
    run_txn(2, CTW'(640'hC2), CTW'(640'h13), HMW'(128'h23), 0, 0);
    req_val = '0;
  endtask

  task automatic test_dec_stall();
    logic [CTW-1:0] big;
    big = '0;
    big[639:600] = 40'hDEAD_BEEF_01;
    big[7:0]     = 8'h5A;
    set_ct(3, big);
    set_ct(0, CTW'(1));
    req_val = 4'b1000;
    // last_grant is 2 here, so requester 3 is searched first
    run_txn(3, big, ~big, '1, 10, 0);
    req_val = '0;
  endtask

  task automatic test_resp_backpressure();
    set_ct(1, CTW'(640'h77));
    req_val = 4'b0010;
    run_txn(1, CTW'(640'h77), CTW'(640'h99), HMW'(128'h55AA), 0, 8);
    req_val = '0;
  endtask

  task automatic test_reset_mid();
    set_ct(0, CTW'(640'h10));
    set_ct(1, CTW'(640'h11));
    req_val = 4'b0001;
    run_txn(0, CTW'(640'h10), CTW'(640'h30), HMW'(128'h40), 0, 0);
    // start a grant to requester 1 and abandon it in WAIT_RESP
    req_val = 4'b0010;
    @(negedge clk);
    req_val     = '0;
    dec_req_rdy = 1'b1;
    @(negedge clk);
    dec_req_rdy = 1'b0;
    #1;
    checks++;
    if (dec_resp_rdy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_wait: got drr=%b want 1", dec_resp_rdy);
    end
    test_reset();
    // reset pointer is 3 so 0 must win over 1; a retained pointer would pick 1
    req_val = 4'b0011;
    run_txn(0, CTW'(640'h10), CTW'(640'h31), HMW'(128'h41), 0, 0);
    req_val = '0;
  endtask

  initial begin
    rst_n              = 1'b0;
    req_ciphertext     = '0;
    req_val            = '0;
    resp_rdy           = '0;
    dec_req_rdy        = 1'b0;
    dec_resp_val       = 1'b0;
    dec_resp_plaintext = '0;
    dec_resp_hmac      = '0;
    test_single();
    test_round_robin();
    test_contention();
    test_dec_stall();
    test_resp_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
